// File: rtl/tlul_host_arb2.sv
// tlul_host_arb2: merges Ibex I/D TL-UL host ports into one round-robin host port.
// Optional TLUL_HOST_ARB_STALL_CNT_EN adds per-port 16-bit saturating stall counters.
package tlul_pkg;
  localparam int TL_AIW = 8;
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [31:0]       d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arb2 import tlul_pkg::*; #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ResetPrio      = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i_h2d_i,
  output tl_d2h_t tl_i_d2h_o,
  input  tl_h2d_t tl_d_h2d_i,
  output tl_d2h_t tl_d_d2h_o,
  output tl_h2d_t tl_h2d_o,
  input  tl_d2h_t tl_d2h_i,
  output logic    spurious_rsp_o,
`ifdef TLUL_HOST_ARB_STALL_CNT_EN
  output logic    idle_o,
  output logic [15:0] stall_cnt_i_o,
  output logic [15:0] stall_cnt_d_o
`else
  output logic    idle_o
`endif
);
  localparam logic [3:0] CntMax = 4'(MaxOutstanding);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e     state_q;
  logic       lock_q, rr_q, sel, dst, a_hs, d_hs, spurious_q;
  logic [3:0] cnt_q [2];
  logic [1:0] a_valid, elig, a_ready, inc, dec;
  tl_h2d_t    req;
  tl_d2h_t    rsp;
  assign a_valid = {tl_d_h2d_i.a_valid, tl_i_h2d_i.a_valid};
  assign sel = (state_q == LOCKED) ? lock_q : (&elig ? rr_q : elig[1]);
  assign dst = tl_d2h_i.d_source[0];
  assign req = sel ? tl_d_h2d_i : tl_i_h2d_i;
  assign a_hs = tl_h2d_o.a_valid && tl_d2h_i.a_ready;
  assign d_hs = tl_d2h_i.d_valid && tl_h2d_o.d_ready;
  for (genvar i = 0; i < 2; i++) begin : g_port
    assign elig[i] = a_valid[i] && cnt_q[i] < CntMax;
    assign a_ready[i] = !rst_i && sel == 1'(i) && tl_d2h_i.a_ready && cnt_q[i] < CntMax;
    assign inc[i] = a_hs && sel == 1'(i);
    assign dec[i] = d_hs && dst == 1'(i);
  end
  always_comb begin
    tl_h2d_o = req;
    tl_h2d_o.a_source = {req.a_source[TL_AIW-2:0], sel};
    tl_h2d_o.a_valid = elig[sel] && !rst_i;
    tl_h2d_o.d_ready = (dst ? tl_d_h2d_i.d_ready : tl_i_h2d_i.d_ready) && !rst_i;
    rsp = tl_d2h_i;
    rsp.d_source = {1'b0, tl_d2h_i.d_source[TL_AIW-1:1]};
    tl_i_d2h_o = rsp;
    tl_i_d2h_o.d_valid = tl_d2h_i.d_valid && !dst && !rst_i;
    tl_i_d2h_o.a_ready = a_ready[0];
    tl_d_d2h_o = rsp;
    tl_d_d2h_o.d_valid = tl_d2h_i.d_valid && dst && !rst_i;
    tl_d_d2h_o.a_ready = a_ready[1];
  end
  // Lock holds a stalled output beat on its port until the crossbar accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q <= 1'b0;
      rr_q <= ResetPrio;
      spurious_q <= 1'b0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      state_q <= (state_q == IDLE) ? ((tl_h2d_o.a_valid && !tl_d2h_i.a_ready) ? LOCKED : IDLE)
                                   : ((a_hs || !tl_h2d_o.a_valid) ? IDLE : LOCKED);
      if (state_q == IDLE) lock_q <= sel;
      if (a_hs) rr_q <= ~sel;
      spurious_q <= d_hs && cnt_q[dst] == 4'd0;
      for (int p = 0; p < 2; p++) begin
        if (inc[p] && !dec[p]) cnt_q[p] <= cnt_q[p] + 4'd1;
        else if (dec[p] && !inc[p] && cnt_q[p] != 4'd0) cnt_q[p] <= cnt_q[p] - 4'd1;
      end
    end
  end
  assign spurious_rsp_o = spurious_q;
  assign idle_o = cnt_q[0] == 4'd0 && cnt_q[1] == 4'd0 && !(|a_valid);
`ifdef TLUL_HOST_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_i_o <= '0;
      stall_cnt_d_o <= '0;
    end else begin
      if (a_valid[0] && !a_ready[0] && stall_cnt_i_o != 16'hFFFF) stall_cnt_i_o <= stall_cnt_i_o + 16'd1;
      if (a_valid[1] && !a_ready[1] && stall_cnt_d_o != 16'hFFFF) stall_cnt_d_o <= stall_cnt_d_o + 16'd1;
    end
  end
`endif
`ifndef SYNTHESIS
  logic [$bits(tl_h2d_t)-2:0] a_beat;
  assign a_beat = tl_h2d_o[$bits(tl_h2d_t)-1:1];
  a_src_i_msb: assert property (@(posedge clk_i) disable iff (rst_i)
    tl_i_h2d_i.a_valid |-> !tl_i_h2d_i.a_source[TL_AIW-1]);
  a_src_d_msb: assert property (@(posedge clk_i) disable iff (rst_i)
    tl_d_h2d_i.a_valid |-> !tl_d_h2d_i.a_source[TL_AIW-1]);
  a_beat_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (tl_h2d_o.a_valid && !tl_d2h_i.a_ready) |=> $stable(a_beat));
`endif
endmodule
